// File: rtl/switch_pio_pkg.sv
// Shared constants for the switch debounce/capture PIO: register offsets and bus width.
package switch_pio_pkg;

   localparam int DATA_W           = 32;
   localparam int DEBOUNCE_DEFAULT = 50000;

   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_TS   = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } reg_addr_e;

endpackage

// File: rtl/switch_debounce_capture_if.sv
// Avalon-MM slave bus bundle for the switch PIO (word address, active-low write).
interface switch_debounce_capture_if;
   import switch_pio_pkg::*;

   logic [1:0]        address;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, write_n, writedata, input readdata);
   modport slave  (input address, write_n, writedata, output readdata);

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, hold-time debounce counter, stable level and one-cycle change pulse.
module switch_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable,
   output logic chg
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   // chg is raised on the same edge stable flips, so it is high while the new level is visible
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
         chg    <= 1'b0;
      end else begin
         s1  <= raw;
         s2  <= s1;
         chg <= 1'b0;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
            chg    <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_debounce_capture.sv
// Debounced switch bank with sticky edge capture, irq mask and level irq.
// Optional change timestamp register at address 1 when SWITCH_TIMESTAMP_EN is defined.
module switch_debounce_capture
   import switch_pio_pkg::*;
#(
   parameter int WIDTH           = 9,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   switch_debounce_capture_if.slave  bus,
   input  logic [WIDTH-1:0]          in_port,
   output logic                      irq
);

   logic [WIDTH-1:0]  stable, chg, irqmask, edgecap, clr_mask;
   logic [DATA_W-1:0] rd_next, ts_rd;
   logic              wr_mask, wr_edge;
   logic              unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (in_port[i]),
         .stable  (stable[i]),
         .chg     (chg[i])
      );
   end

   assign wr_mask      = !bus.write_n && (bus.address == ADDR_MASK);
   assign wr_edge      = !bus.write_n && (bus.address == ADDR_EDGE);
   assign clr_mask     = wr_edge ? bus.writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^bus.writedata[DATA_W-1:WIDTH];

`ifdef SWITCH_TIMESTAMP_EN
   logic [DATA_W-1:0] ts_cnt, ts_latch;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ts_cnt   <= '0;
         ts_latch <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (|chg) ts_latch <= ts_cnt;
      end
   end

   assign ts_rd = ts_latch;
`else
   assign ts_rd = '0;
`endif

   always_comb begin
      rd_next = '0;
      case (bus.address)
         ADDR_DATA: rd_next[WIDTH-1:0] = stable;
         ADDR_TS:   rd_next            = ts_rd;
         ADDR_MASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGE: rd_next[WIDTH-1:0] = edgecap;
         default:   rd_next            = '0;
      endcase
   end

   // a new edge on a bit being cleared in the same cycle survives the clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irqmask      <= '0;
         edgecap      <= '0;
         irq          <= 1'b0;
         bus.readdata <= '0;
      end else begin
         if (wr_mask) irqmask <= bus.writedata[WIDTH-1:0];
         edgecap      <= (edgecap & ~clr_mask) | chg;
         irq          <= |(edgecap & irqmask);
         bus.readdata <= rd_next;
      end
   end

endmodule
